// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM stage: access-size encodings, FSM states
// and the sizing helper for the bus timeout counter.
package mips_mem_pkg;

   localparam logic [1:0] BHW_WORD = 2'b00;
   localparam logic [1:0] BHW_HALF = 2'b01;
   localparam logic [1:0] BHW_BYTE = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } memState_t;

   // The counter only ever needs to reach TIMEOUT_CYCLES-1
   function automatic int unsigned timeoutCntWidth(input int unsigned cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction

   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
   localparam int unsigned DEFAULT_TIMEOUT_CNT_W  = timeoutCntWidth(DEFAULT_TIMEOUT_CYCLES);

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave):
// req/ack handshake, word address, byte enables and data in both directions.
interface mem_access_stage_if;

   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_rdata, dmem_ack
   );

endinterface

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: alignment check, store replication and byte
// enables, plus load byte/halfword extraction with sign or zero extension.
module mem_lane_align
   import mips_mem_pkg::*;
(
   input  logic [1:0]  i_bhw,
   input  logic [1:0]  i_addrLow,
   input  logic        i_isStore,
   input  logic        i_extSign,
   input  logic [31:0] i_storeData,
   input  logic [31:0] i_rdata,
   output logic        o_misalign,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_loadData
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Loads always fetch the whole word; only stores narrow the byte enables
   always_comb begin
      o_misalign = 1'b0;
      o_be       = 4'b1111;
      o_wdata    = i_storeData;
      case (i_bhw)
         BHW_HALF: begin
            o_misalign = i_addrLow[0];
            o_wdata    = {2{i_storeData[15:0]}};
            if (i_isStore) o_be = i_addrLow[1] ? 4'b0011 : 4'b1100;
         end
         BHW_BYTE: begin
            o_wdata = {4{i_storeData[7:0]}};
            if (i_isStore) o_be = 4'b1000 >> i_addrLow;
         end
         default: o_misalign = |i_addrLow;
      endcase
   end

   always_comb begin
      case (i_addrLow)
         2'b00:   w_byte = i_rdata[31:24];
         2'b01:   w_byte = i_rdata[23:16];
         2'b10:   w_byte = i_rdata[15:8];
         default: w_byte = i_rdata[7:0];
      endcase
      w_half = i_addrLow[1] ? i_rdata[15:0] : i_rdata[31:16];
      case (i_bhw)
         BHW_HALF: o_loadData = {{16{i_extSign & w_half[15]}}, w_half};
         BHW_BYTE: o_loadData = {{24{i_extSign & w_byte[7]}}, w_byte};
         default:  o_loadData = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: launches data-memory accesses, stalls upstream while
// waiting for ack (with a timeout abort), and registers the MEM/WB boundary.
module mem_access_stage
   import mips_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mem_read,
   input  logic                mem_write,
   input  logic [1:0]          bhw,
   input  logic                ext_sign,
   input  logic [31:0]         alu_result,
   input  logic [31:0]         store_data,
   input  logic                reg_write,
   input  logic [4:0]          write_reg_addr,
   input  logic [1:0]          mem_to_reg,
   input  logic [31:0]         next_instr,
   mem_access_stage_if.master  dmem,
   output logic                stall,
   output logic                misalign_exc,
   output logic                bus_err,
   output logic                wb_reg_write,
   output logic [4:0]          wb_write_reg_addr,
   output logic [1:0]          wb_mem_to_reg,
   output logic [31:0]         wb_load_data,
   output logic [31:0]         wb_alu_result,
   output logic [31:0]         wb_next_instr
);

   localparam int unsigned      CNT_W    = timeoutCntWidth(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   memState_t        r_state, w_nextState;
   logic [CNT_W-1:0] r_count;
   logic             w_memOp, w_isStore, w_misalign, w_expired;
   logic             w_req, w_stall, w_complete, w_timeout;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata, w_loadData;

   logic             r_misalign, r_busErr, r_wbRegWrite;
   logic [4:0]       r_wbWriteRegAddr;
   logic [1:0]       r_wbMemToReg;
   logic [31:0]      r_wbLoadData, r_wbAluResult, r_wbNextInstr;

   assign w_memOp   = mem_read | mem_write;
   assign w_isStore = mem_write & ~mem_read;
   assign w_expired = (r_count == CNT_LAST);

   mem_lane_align u_laneAlign (
      .i_bhw       (bhw),
      .i_addrLow   (alu_result[1:0]),
      .i_isStore   (w_isStore),
      .i_extSign   (ext_sign),
      .i_storeData (store_data),
      .i_rdata     (dmem.dmem_rdata),
      .o_misalign  (w_misalign),
      .o_be        (w_be),
      .o_wdata     (w_wdata),
      .o_loadData  (w_loadData)
   );

   // Ack in the launch cycle is ignored because IDLE never looks at it
   always_comb begin
      w_nextState = r_state;
      w_req       = 1'b0;
      w_stall     = 1'b0;
      w_complete  = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_memOp && !w_misalign) begin
               w_req       = 1'b1;
               w_stall     = 1'b1;
               w_nextState = WAIT;
            end
         end
         WAIT: begin
            w_req = !w_expired;
            if (dmem.dmem_ack) begin
               w_complete  = 1'b1;
               w_nextState = IDLE;
            end else if (w_expired) begin
               w_timeout   = 1'b1;
               w_nextState = IDLE;
            end else begin
               w_stall = 1'b1;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   assign dmem.dmem_req   = w_req;
   assign dmem.dmem_we    = w_req & w_isStore;
   assign dmem.dmem_addr  = {alu_result[31:2], 2'b00};
   assign dmem.dmem_be    = w_be;
   assign dmem.dmem_wdata = w_wdata;
   assign stall           = w_stall;

   // Writeback is enabled only for a plain ALU op or a completed access
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= IDLE;
         r_count          <= '0;
         r_misalign       <= 1'b0;
         r_busErr         <= 1'b0;
         r_wbRegWrite     <= 1'b0;
         r_wbWriteRegAddr <= '0;
         r_wbMemToReg     <= '0;
         r_wbLoadData     <= '0;
         r_wbAluResult    <= '0;
         r_wbNextInstr    <= '0;
      end else begin
         r_state          <= w_nextState;
         r_count          <= (w_nextState == IDLE) ? '0 :
                             (r_state == WAIT)     ? r_count + 1'b1 : r_count;
         r_misalign       <= (r_state == IDLE) && w_memOp && w_misalign;
         r_busErr         <= w_timeout;
         r_wbRegWrite     <= reg_write && (w_complete || (r_state == IDLE && !w_memOp));
         r_wbWriteRegAddr <= write_reg_addr;
         r_wbMemToReg     <= mem_to_reg;
         r_wbLoadData     <= (w_complete && !w_isStore) ? w_loadData : '0;
         r_wbAluResult    <= alu_result;
         r_wbNextInstr    <= next_instr;
      end
   end

   assign misalign_exc      = r_misalign;
   assign bus_err           = r_busErr;
   assign wb_reg_write      = r_wbRegWrite;
   assign wb_write_reg_addr = r_wbWriteRegAddr;
   assign wb_mem_to_reg     = r_wbMemToReg;
   assign wb_load_data      = r_wbLoadData;
   assign wb_alu_result     = r_wbAluResult;
   assign wb_next_instr     = r_wbNextInstr;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios followed by
// randomized accesses, checked against an arithmetic lane/latency model.
module tb_mem_access_stage;
   import mips_mem_pkg::*;

   localparam int unsigned TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        memRead, memWrite, extSign, regWrite;
   logic [1:0]  bhw, memToReg;
   logic [31:0] aluResult, storeData, nextInstr;
   logic [4:0]  writeRegAddr;
   logic        stall, misalignExc, busErr, wbRegWrite;
   logic [4:0]  wbWriteRegAddr;
   logic [1:0]  wbMemToReg;
   logic [31:0] wbLoadData, wbAluResult, wbNextInstr;

   int checks   = 0;
   int failures = 0;

   mem_access_stage_if dmemBus();

   mem_access_stage #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk               (clk),
      .rst               (rst),
      .mem_read          (memRead),
      .mem_write         (memWrite),
      .bhw               (bhw),
      .ext_sign          (extSign),
      .alu_result        (aluResult),
      .store_data        (storeData),
      .reg_write         (regWrite),
      .write_reg_addr    (writeRegAddr),
      .mem_to_reg        (memToReg),
      .next_instr        (nextInstr),
      .dmem              (dmemBus),
      .stall             (stall),
      .misalign_exc      (misalignExc),
      .bus_err           (busErr),
      .wb_reg_write      (wbRegWrite),
      .wb_write_reg_addr (wbWriteRegAddr),
      .wb_mem_to_reg     (wbMemToReg),
      .wb_load_data      (wbLoadData),
      .wb_alu_result     (wbAluResult),
      .wb_next_instr     (wbNextInstr)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Reference model: an access covers sz bytes starting at byte offset addr%4, MSB first
   function automatic int accessSize(input logic [1:0] size);
      return (size == 2'b01) ? 2 : (size == 2'b10) ? 1 : 4;
   endfunction

   function automatic logic [3:0] expBe(input int sz, input logic [31:0] addr, input logic isStore);
      logic [3:0] be;
      int start;
      if (!isStore) return 4'hF;
      be    = 4'h0;
      start = int'(addr % 4);
      for (int i = 0; i < 4; i++)
         if (i >= start && i < start + sz) be[3-i] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] expWdata(input int sz, input logic [31:0] sd);
      logic [31:0] w;
      w = 32'h0;
      for (int i = 0; i < 4; i++)
         w[31-8*i -: 8] = 8'(sd >> (8 * ((sz - 1) - (i % sz))));
      return w;
   endfunction

   function automatic logic [31:0] expLoad(input int sz, input logic sgn, input logic [31:0] addr,
                                           input logic [31:0] rdata);
      logic [63:0] mask, val;
      int start;
      start = int'(addr % 4);
      mask  = (64'd1 << (8 * sz)) - 64'd1;
      val   = ({32'h0, rdata} >> (8 * (4 - start - sz))) & mask;
      if (sgn && val[8*sz-1]) val = val | ~mask;
      return val[31:0];
   endfunction

   // One EX/MEM instruction, cycle by cycle, followed by an ALU op that must retire at once
   task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                                input int latency, input logic spurious, input logic rw,
                                input logic [4:0] wra, input logic [1:0] m2r, input logic [31:0] nxt);
      logic memOp, isStore, misal, done;
      int sz;
      memOp   = rd | wr;
      isStore = wr & ~rd;
      sz      = accessSize(size);
      misal   = memOp && ((addr % sz) != 0);
      @(negedge clk);
      memRead = rd; memWrite = wr; bhw = size; extSign = sgn; aluResult = addr;
      storeData = sd; regWrite = rw; writeRegAddr = wra; memToReg = m2r; nextInstr = nxt;
      dmemBus.dmem_rdata = rdata;
      dmemBus.dmem_ack   = 1'b0;
      if (!memOp || misal) begin
         #1;
         checkOutput("stall_no_launch", stall, 0);
         checkOutput("req_no_launch", dmemBus.dmem_req, 0);
         @(posedge clk); #1;
         checkOutput("misalign_exc", misalignExc, misal);
         checkOutput("wb_reg_write_direct", wbRegWrite, rw & ~memOp);
         checkOutput("wb_alu_result_direct", wbAluResult, addr);
         checkOutput("wb_write_reg_addr", wbWriteRegAddr, wra);
         checkOutput("wb_load_data_direct", wbLoadData, 0);
      end else begin
         dmemBus.dmem_ack = spurious;
         #1;
         checkOutput("req_launch", dmemBus.dmem_req, 1);
         checkOutput("stall_launch", stall, 1);
         checkOutput("we_launch", dmemBus.dmem_we, isStore);
         checkOutput("addr_launch", dmemBus.dmem_addr, addr & 32'hFFFF_FFFC);
         checkOutput("be_launch", dmemBus.dmem_be, expBe(sz, addr, isStore));
         if (isStore) checkOutput("wdata_launch", dmemBus.dmem_wdata, expWdata(sz, sd));
         @(posedge clk); #1;
         checkOutput("wb_reg_write_launch", wbRegWrite, 0);
         done = 1'b0;
         for (int k = 1; k <= int'(TIMEOUT) && !done; k++) begin
            @(negedge clk);
            dmemBus.dmem_ack = (k == latency);
            #1;
            if (k == latency) begin
               checkOutput("req_ack", dmemBus.dmem_req, 1);
               checkOutput("stall_ack", stall, 0);
            end else if (k == int'(TIMEOUT)) begin
               checkOutput("req_timeout", dmemBus.dmem_req, 0);
               checkOutput("stall_timeout", stall, 0);
            end else begin
               checkOutput("req_wait", dmemBus.dmem_req, 1);
               checkOutput("stall_wait", stall, 1);
               checkOutput("addr_wait", dmemBus.dmem_addr, addr & 32'hFFFF_FFFC);
            end
            @(posedge clk); #1;
            if (k == latency) begin
               checkOutput("wb_reg_write_ack", wbRegWrite, rw);
               checkOutput("wb_load_data_ack", wbLoadData, isStore ? 32'h0 : expLoad(sz, sgn, addr, rdata));
               checkOutput("wb_alu_result_ack", wbAluResult, addr);
               checkOutput("wb_next_instr_ack", wbNextInstr, nxt);
               checkOutput("wb_mem_to_reg_ack", wbMemToReg, m2r);
               checkOutput("bus_err_ack", busErr, 0);
               done = 1'b1;
            end else if (k == int'(TIMEOUT)) begin
               checkOutput("bus_err_timeout", busErr, 1);
               checkOutput("wb_reg_write_timeout", wbRegWrite, 0);
               done = 1'b1;
            end else begin
               checkOutput("wb_reg_write_wait", wbRegWrite, 0);
               checkOutput("bus_err_wait", busErr, 0);
            end
         end
      end
      @(negedge clk);
      memRead = 1'b0; memWrite = 1'b0; regWrite = 1'b1; aluResult = $urandom;
      writeRegAddr = 5'($urandom); memToReg = 2'($urandom); nextInstr = $urandom;
      dmemBus.dmem_ack = 1'b0;
      #1;
      checkOutput("stall_alu", stall, 0);
      checkOutput("req_alu", dmemBus.dmem_req, 0);
      @(posedge clk); #1;
      checkOutput("wb_reg_write_alu", wbRegWrite, 1);
      checkOutput("wb_alu_result_alu", wbAluResult, aluResult);
      checkOutput("wb_next_instr_alu", wbNextInstr, nextInstr);
      checkOutput("wb_load_data_alu", wbLoadData, 0);
      checkOutput("misalign_pulse_end", misalignExc, 0);
      checkOutput("bus_err_pulse_end", busErr, 0);
   endtask

   initial begin
      int          kind;
      logic [31:0] rAddr, rSd, rData;
      logic        rRd, rWr;

      rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; bhw = BHW_WORD; extSign = 1'b0;
      aluResult = 32'h0; storeData = 32'h0; regWrite = 1'b0; writeRegAddr = 5'd0;
      memToReg = 2'd0; nextInstr = 32'h0;
      dmemBus.dmem_ack = 1'b0; dmemBus.dmem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("reset_req", dmemBus.dmem_req, 0);
      checkOutput("reset_we", dmemBus.dmem_we, 0);
      checkOutput("reset_stall", stall, 0);
      checkOutput("reset_wb_reg_write", wbRegWrite, 0);
      checkOutput("reset_wb_alu_result", wbAluResult, 0);
      checkOutput("reset_misalign", misalignExc, 0);
      checkOutput("reset_bus_err", busErr, 0);

      // lb 0x1003, ack three cycles after launch
      applyStimulus(1, 0, BHW_BYTE, 1, 32'h1003, 32'h0, 32'h112233F0, 3, 0, 1, 5'd8, 2'd1, 32'h104);
      // lhu 0x2002, ack on WAIT entry, with a stray ack during launch
      applyStimulus(1, 0, BHW_HALF, 0, 32'h2002, 32'h0, 32'hAAAA8001, 1, 1, 1, 5'd9, 2'd1, 32'h108);
      // sb 0x3001
      applyStimulus(0, 1, BHW_BYTE, 0, 32'h3001, 32'h000000AB, 32'h0, 1, 0, 0, 5'd0, 2'd0, 32'h10C);
      // lw 0x4002 misaligned
      applyStimulus(1, 0, BHW_WORD, 0, 32'h4002, 32'h0, 32'h0, 1, 0, 1, 5'd3, 2'd1, 32'h110);
      // lw 0x5000 never acked
      applyStimulus(1, 0, BHW_WORD, 0, 32'h5000, 32'h0, 32'h0, 0, 0, 1, 5'd4, 2'd1, 32'h114);

      // Reset during the second WAIT cycle
      @(negedge clk);
      memRead = 1'b1; memWrite = 1'b0; bhw = BHW_WORD; aluResult = 32'h6000; regWrite = 1'b1;
      writeRegAddr = 5'd7; memToReg = 2'd1; nextInstr = 32'h118; dmemBus.dmem_ack = 1'b0;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("req_before_reset", dmemBus.dmem_req, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("rst_wb_reg_write", wbRegWrite, 0);
      checkOutput("rst_wb_alu_result", wbAluResult, 0);
      checkOutput("rst_wb_next_instr", wbNextInstr, 0);
      checkOutput("rst_wb_write_reg_addr", wbWriteRegAddr, 0);
      checkOutput("rst_wb_mem_to_reg", wbMemToReg, 0);
      checkOutput("rst_wb_load_data", wbLoadData, 0);
      @(negedge clk);
      rst = 1'b0; memRead = 1'b0; regWrite = 1'b0;
      #1;
      checkOutput("post_reset_req", dmemBus.dmem_req, 0);
      checkOutput("post_reset_stall", stall, 0);
      applyStimulus(1, 0, BHW_WORD, 0, 32'h7004, 32'h0, 32'hDEADBEEF, 3, 0, 1, 5'd10, 2'd1, 32'h11C);

      for (int n = 0; n < 40; n++) begin
         kind  = $urandom_range(0, 3);
         rRd   = (kind == 1) || (kind == 3);
         rWr   = (kind == 2) || (kind == 3);
         rAddr = $urandom;
         rSd   = $urandom;
         rData = $urandom;
         applyStimulus(rRd, rWr, 2'($urandom), 1'($urandom), rAddr, rSd, rData,
                       $urandom_range(0, TIMEOUT - 1), 1'($urandom), 1'($urandom),
                       5'($urandom), 2'($urandom), $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Consumer of the EX/MEM pipeline register outputs in the 5-stage MIPS pipeline.
- Drives a variable-latency data-memory bus with a req/ack handshake and performs byte/halfword/word lane steering with sign or zero extension.
- Stalls upstream stages while an access is outstanding, then registers results into the MEM/WB boundary.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles in WAIT before the access is aborted (1..65535).

Ports:
- clk  in  1  pipeline clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  load in EX/MEM
- mem_write  in  1  store in EX/MEM
- bhw  in  2  access size: 00 word, 01 halfword, 10 byte, 11 treated as word
- ext_sign  in  1  1 = sign-extend loads, 0 = zero-extend
- alu_result  in  32  effective address, or ALU result for non-memory ops
- store_data  in  32  rt value, right-justified for sb/sh
- reg_write  in  1  writeback enable from EX/MEM
- write_reg_addr  in  5  destination register
- mem_to_reg  in  2  writeback select, passed through
- next_instr  in  32  PC+4, passed through (jal)
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({alu_result[31:2],2'b00})
- dmem_be  out  4  byte enables, be[3] = bits 31:24
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  read data, valid with ack
- dmem_ack  in  1  single-cycle completion pulse
- stall  out  1  combinational; upstream holds EX/MEM when 1
- misalign_exc  out  1  registered 1-cycle pulse
- bus_err  out  1  registered 1-cycle pulse on timeout
- wb_reg_write  out  1  MEM/WB regwrite
- wb_write_reg_addr  out  5
- wb_mem_to_reg  out  2
- wb_load_data  out  32  extended load result
- wb_alu_result  out  32
- wb_next_instr  out  32

Behaviour:
- Reset: state IDLE, timeout counter 0; every registered output (wb_*, misalign_exc, bus_err) is 0. dmem_req, dmem_we and stall read 0 in the cycle after reset. A reset in WAIT drops dmem_req at that edge, and the pending access is discarded.
- Byte order is big-endian. For bytes, addr[1:0]=00 selects bits 31:24; for halfwords, addr[1]=0 selects bits 31:16.
- Mem op = mem_read|mem_write. If both are set, the op is a read and dmem_we=0.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - No request is issued and stall=0.
  - Next edge: misalign_exc=1, wb_reg_write=0; the other wb_* fields are captured normally.
- Non-memory op in IDLE: stall=0. All wb_* fields capture the inputs at the next edge (1-cycle latency); wb_load_data=0.
- Aligned mem op in IDLE (launch cycle):
  - dmem_req=1 combinationally from the inputs, and stall=1.
  - Next state is WAIT. wb_reg_write<=0 (bubble).
  - If dmem_ack arrives in the launch cycle, it is ignored.
- WAIT state:
  - dmem_req=1; addr, be, wdata and we are held from the stable EX/MEM inputs.
  - stall = ~dmem_ack.
  - On ack: wb_* capture the inputs, wb_load_data gets the steered and extended dmem_rdata (0 for stores), and the state returns to IDLE. Minimum mem-op latency is 2 cycles.
  - Each non-ack cycle: counter increments and wb_reg_write<=0.
- Timeout: when the counter reaches TIMEOUT_CYCLES-1 without ack:
  - dmem_req drops, bus_err pulses, and wb_reg_write<=0.
  - The state returns to IDLE with stall=0 in that cycle, so the instruction retires as a bubble.
  - The counter clears on every entry to IDLE.
- Store lanes:
  - Byte: wdata = {4{store_data[7:0]}}, be = 1000 >> addr[1:0].
  - Halfword: wdata = {2{store_data[15:0]}}, be = addr[1] ? 0011 : 1100.
  - Word: be = 1111.
- Loads read all 4 bytes (be = 1111). Extension uses ext_sign.

Decomposition:
- Shared package mips_mem_pkg holds:
  - the BHW_WORD/BHW_HALF/BHW_BYTE encodings
  - the state enum {IDLE, WAIT}
  - the width constant for the timeout counter, derived from TIMEOUT_CYCLES
- Combinational sub-module mem_lane_align holds the misalign check, store replication/byte enables, and load extraction/extension.
- The FSM, counter and MEM/WB registers live in the top.

Test Plan:
1. lb, addr 0x1003, ext_sign=1, ack 3 cycles after launch returning 0x112233F0 -> stall high 3 cycles, then wb_load_data=0xFFFFFFF0, wb_reg_write=1.
2. lhu, addr 0x2002, ack same cycle as WAIT entry returning 0xAAAA8001 -> 2-cycle latency, wb_load_data=0x00008001.
3. sb, addr 0x3001, store_data 0x000000AB -> dmem_we=1, dmem_be=0100, dmem_wdata=0xABABABAB, dmem_addr=0x3000; wb_reg_write=0.
4. lw, addr 0x4002 -> no dmem_req, misalign_exc pulse 1 cycle, wb_reg_write=0, stall never asserted.
5. TIMEOUT_CYCLES=4, lw 0x5000, no ack -> dmem_req high 4 cycles, then bus_err pulse, stall=0, wb_reg_write=0, then an ALU op retires normally the next cycle.
6. rst asserted during cycle 2 of WAIT -> dmem_req=0 and all wb_* = 0 after that edge; a later lw completes normally.
